// File: rtl/seq_gen_if.sv
// seq_gen_if: frame request / serial output bundle for seq_gen.
//
// Handshake: Load is a request and Ready is the acceptance indication.
// A frame starts on the rising Clk edge where Load=1 and Ready=1. Load
// sampled while Ready=0 is dropped (no queuing). Din is only looked at on
// that accepting edge. X/Busy/Done are Moore outputs of the frame engine.
interface seq_gen_if;
  logic [7:0] Din;
  logic       Load;
  logic       Ready;
  logic       X;
  logic       Busy;
  logic       Done;
  logic [1:0] dbg_state;

  // Frame source side: supplies data and the start request.
  modport master (
    output Din,
    output Load,
    input  Ready,
    input  X,
    input  Busy,
    input  Done,
    input  dbg_state
  );

  // Frame engine side (seq_gen).
  modport slave (
    input  Din,
    input  Load,
    output Ready,
    output X,
    output Busy,
    output Done,
    output dbg_state
  );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: parallel-to-serial frame generator, MSB first, Moore outputs.
// A captured byte is shifted out on X one bit per cycle, optionally followed
// by an odd-parity bit, then a one-cycle Done pulse before returning to IDLE.
// Optional feature macro: SEQ_GEN_PARITY_EN (adds the PARITY state).
// Clr is a synchronous active-high clear and takes priority over Load.
module seq_gen (
  input  logic     Clk,
  input  logic     Clr,
  seq_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef SEQ_GEN_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_e;

  // Declaration initialisers give the power-up values, identical to the
  // values applied by Clr.
  state_e     state_q = S_IDLE;
  state_e     state_d;
  logic [7:0] shift_q = 8'h00;
  logic [7:0] shift_d;
  logic [2:0] cnt_q   = 3'd0;
  logic [2:0] cnt_d;
`ifdef SEQ_GEN_PARITY_EN
  logic       par_q   = 1'b0;
  logic       par_d;
`endif

  // Accepting edge: the one the handshake comment in seq_gen_if describes.
  logic accept;
  assign accept = (state_q == S_IDLE) && bus.Load;

  // State and datapath registers; Clr overrides everything, including Load.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_IDLE;
      shift_q <= 8'h00;
      cnt_q   <= 3'd0;
`ifdef SEQ_GEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: the counter reaching 7 marks the last data bit on X.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == 3'd7) begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, shift/count while in SHIFT.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef SEQ_GEN_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      shift_d = bus.Din;
      cnt_d   = 3'd0;
`ifdef SEQ_GEN_PARITY_EN
      par_d   = 1'b0;
`endif
    end else if (state_q == S_SHIFT) begin
      shift_d = {shift_q[6:0], 1'b0};
      cnt_d   = cnt_q + 3'd1;
`ifdef SEQ_GEN_PARITY_EN
      // Accumulate the XOR of each bit as it leaves on X.
      par_d   = par_q ^ shift_q[7];
`endif
    end
  end

  // Moore output decode from registered state and shift data only.
  always_comb begin
    bus.Ready     = 1'b0;
    bus.Busy      = 1'b0;
    bus.Done      = 1'b0;
    bus.X         = 1'b0;
    bus.dbg_state = state_q;
    case (state_q)
      S_IDLE: begin
        bus.Ready = 1'b1;
      end
      S_SHIFT: begin
        bus.Busy = 1'b1;
        bus.X    = shift_q[7];
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        bus.Busy = 1'b1;
        bus.X    = ~par_q;
      end
`endif
      S_DONE: begin
        bus.Done = 1'b1;
      end
      default: begin
        bus.Ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized self-checking bench for seq_gen.
// Build with +define+SEQ_GEN_PARITY_EN to exercise the parity variant.
module tb_seq_gen;

`ifdef SEQ_GEN_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  seq_gen_if bus ();

  seq_gen dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus.slave)
  );

  // Clock: 10 time-unit period; bench samples and drives on the falling edge.
  always #5 clk = ~clk;

  // Reference frame: data bits MSB first, then (optionally) odd parity
  // defined as "1 when the word holds an even number of ones".
  function automatic void build_frame(input logic [7:0] d, output logic q[$]);
    int ones;
    q = {};
    ones = 0;
    for (int i = 7; i >= 0; i--) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
`ifdef SEQ_GEN_PARITY_EN
    q.push_back((ones % 2) == 0);
`endif
  endfunction

  task automatic test_reset();
    logic [3:0] obs;
    // Before any Clr: power-up state must already be the reset state.
    @(negedge clk);
    obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_errors++;
      $display("FAIL powerup_outputs: got %b expected %b", obs, 4'b1000);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 4'b1000);
    end
  endtask

  // One frame; a stray Load with new Din is applied during bit ld_at
  // (ld_at < 0 disables it). Din is scrambled after capture every cycle.
  task automatic test_frame(input logic [7:0] d, input int ld_at,
                            input logic [7:0] ld_din, input string tag);
    logic       exp_q[$];
    logic [3:0] obs;
    build_frame(d, exp_q);
    obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_errors++;
      $display("FAIL %s_pre_idle: got %b expected %b", tag, obs, 4'b1000);
    end
    bus.Din  = d;
    bus.Load = 1'b1;
    @(negedge clk);
    for (int k = 0; k < FRAME_BITS; k++) begin
      obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
      n_checks++;
      if (obs !== {3'b010, exp_q[k]}) begin
        n_errors++;
        $display("FAIL %s_bit%0d: got RBDX=%b expected %b", tag, k, obs, {3'b010, exp_q[k]});
      end
      if (k == ld_at) begin
        bus.Load = 1'b1;
        bus.Din  = ld_din;
      end else begin
        bus.Load = 1'b0;
        bus.Din  = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end
    bus.Load = 1'b0;
    obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
    n_checks++;
    if (obs !== 4'b0010) begin
      n_errors++;
      $display("FAIL %s_done: got RBDX=%b expected %b", tag, obs, 4'b0010);
    end
    @(negedge clk);
    obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_errors++;
      $display("FAIL %s_post_idle: got RBDX=%b expected %b", tag, obs, 4'b1000);
    end
  endtask

  task automatic test_clr_abort();
    logic       exp_q[$];
    logic [3:0] obs;
    int         done_seen;
    build_frame(8'hC3, exp_q);
    bus.Din  = 8'hC3;
    bus.Load = 1'b1;
    @(negedge clk);
    bus.Load = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
      n_checks++;
      if (obs !== {3'b010, exp_q[k]}) begin
        n_errors++;
        $display("FAIL abort_bit%0d: got RBDX=%b expected %b", k, obs, {3'b010, exp_q[k]});
      end
      if (k == 4) clr = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    clr = 1'b0;
    obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_errors++;
      $display("FAIL abort_idle: got RBDX=%b expected %b", obs, 4'b1000);
    end
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      done_seen += int'(bus.Done) + int'(bus.Busy);
    end
    n_checks++;
    if (done_seen !== 0) begin
      n_errors++;
      $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", done_seen);
    end
  endtask

  task automatic test_clr_load();
    logic [3:0] obs;
    int         busy_seen;
    bus.Din  = 8'h81;
    bus.Load = 1'b1;
    clr      = 1'b1;
    @(negedge clk);
    bus.Load = 1'b0;
    clr      = 1'b0;
    obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_errors++;
      $display("FAIL clr_load_idle: got RBDX=%b expected %b", obs, 4'b1000);
    end
    busy_seen = 0;
    for (int k = 0; k < FRAME_BITS + 2; k++) begin
      @(negedge clk);
      busy_seen += int'(bus.Busy) + int'(bus.Done) + int'(bus.X);
    end
    n_checks++;
    if (busy_seen !== 0) begin
      n_errors++;
      $display("FAIL clr_load_no_frame: got %0d active cycles expected 0", busy_seen);
    end
  endtask

  // Load held high across two frames; X is also fed to a "101" detector.
  task automatic test_back_to_back();
    logic frame_q[$];
    logic exp_x[$];
    logic obs_x[$];
    int   caps[$];
    int   done_cnt;
    int   det_cnt;
    int   ref_cnt;
    logic [2:0] hist;
    bit   just;
    int   total;
    build_frame(8'h5A, frame_q);
    exp_x = {};
    for (int f = 0; f < 2; f++) begin
      exp_x.push_back(1'b0);
      foreach (frame_q[i]) exp_x.push_back(frame_q[i]);
      exp_x.push_back(1'b0);
    end
    total = exp_x.size() + 4;
    while (exp_x.size() < total) exp_x.push_back(1'b0);
    done_cnt = 0;
    det_cnt  = 0;
    hist     = 3'b000;
    bus.Din  = 8'h5A;
    bus.Load = 1'b1;
    for (int c = 0; c < total; c++) begin
      just = 1'b0;
      if (bus.Ready && bus.Load) begin
        caps.push_back(c);
        just = 1'b1;
      end
      done_cnt += int'(bus.Done);
      obs_x.push_back(bus.X);
      hist = {hist[1:0], bus.X};
      if (hist == 3'b101) det_cnt++;
      if (caps.size() >= 2 && !just) bus.Load = 1'b0;
      @(negedge clk);
    end
    bus.Load = 1'b0;
    for (int i = 0; i < total; i++) begin
      n_checks++;
      if (obs_x[i] !== exp_x[i]) begin
        n_errors++;
        $display("FAIL b2b_x_cycle%0d: got %b expected %b", i, obs_x[i], exp_x[i]);
      end
    end
    n_checks++;
    if (caps.size() !== 2) begin
      n_errors++;
      $display("FAIL b2b_captures: got %0d expected 2", caps.size());
    end else begin
      n_checks++;
      if (caps[1] - caps[0] !== FRAME_BITS + 2) begin
        n_errors++;
        $display("FAIL b2b_spacing: got %0d expected %0d", caps[1] - caps[0], FRAME_BITS + 2);
      end
    end
    n_checks++;
    if (done_cnt !== 2) begin
      n_errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", done_cnt);
    end
    ref_cnt = 0;
    for (int i = 2; i < exp_x.size(); i++)
      if (exp_x[i-2] == 1'b1 && exp_x[i-1] == 1'b0 && exp_x[i] == 1'b1) ref_cnt++;
    n_checks++;
    if (det_cnt !== ref_cnt) begin
      n_errors++;
      $display("FAIL b2b_detect_101: got %0d expected %0d", det_cnt, ref_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] obs;
    int gap;
    for (int r = 0; r < 8; r++) begin
      test_frame(8'($urandom_range(0, 255)), $urandom_range(0, FRAME_BITS - 1),
                 8'($urandom_range(0, 255)), "rand");
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        bus.Din = 8'($urandom_range(0, 255));
        @(negedge clk);
        obs = {bus.Ready, bus.Busy, bus.Done, bus.X};
        n_checks++;
        if (obs !== 4'b1000) begin
          n_errors++;
          $display("FAIL rand_gap: got RBDX=%b expected %b", obs, 4'b1000);
        end
      end
    end
  endtask

  initial begin
    bus.Din  = 8'h00;
    bus.Load = 1'b0;
    test_reset();
    test_frame(8'hA5, -1, 8'h00, "a5");
    test_frame(8'hFF, 3, 8'h00, "ff_reload");
    test_clr_abort();
    test_clr_load();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Clr  input  1  synchronous active-high clear, sampled on rising Clk.
REQ-004 Din  input  8  parallel data word to serialize.
REQ-005 Load  input  1  request to start a frame; accepted only when Ready=1.
REQ-006 Ready  output  1  high only in IDLE; the block can accept Load.
REQ-007 X  output  1  serial bit stream, MSB first; drives a serial-input sequence detector.
REQ-008 Busy  output  1  high while frame bits (data or parity) are on X.
REQ-009 Done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-010 The block SHALL be a Moore machine; X, Ready, Busy and Done SHALL be decoded from registered state/shift data only, never combinationally from Load or Din.
REQ-011 The block SHALL have the states IDLE, SHIFT, PARITY (only with the configured feature) and DONE.
REQ-012 IDLE: X=0, Ready=1, Busy=0, Done=0; Load=1 at edge E0 -> capture Din into 8-bit shift register, clear 3-bit bit counter, go to SHIFT.
REQ-013 SHIFT: X = shift_reg[7], Busy=1, Ready=0; each edge shifts left by one and increments counter; X=Din[7] after E0 ... Din[0] after E7.
REQ-014 At E8 (counter wrapped 7->0) SHIFT SHALL go to PARITY if the feature is compiled in, otherwise to DONE.
REQ-015 DONE: X=0, Busy=0, Ready=0, Done=1 for exactly one cycle, then IDLE unconditionally.
REQ-016 Load while not in IDLE SHALL be ignored; no queuing, no effect on the current frame.
REQ-017 Din changes after the capture edge SHALL NOT affect the frame in flight.
REQ-018 Back-to-back frames: minimum Load-to-Load spacing is 10 cycles (11 with parity); Load held high through DONE starts the next frame at the first IDLE edge.
REQ-019 Clr asserted mid-frame SHALL abort: next edge -> IDLE, X=0, no Done pulse.
REQ-020 Clr and Load high on the same edge: Clr SHALL win; no frame starts.

Reset
REQ-021 On Clr: state=IDLE, shift register=8'h00, counter=0, parity accumulator=0.
REQ-022 Output values after reset SHALL be X=0, Ready=1, Busy=0, Done=0.
REQ-023 Before the first Clr, the registers SHALL be initialised to the same reset values.

Configuration
REQ-024 Macro SEQ_GEN_PARITY_EN defined: PARITY state is present; one cycle after E8 with X = odd parity of the captured word (XOR of the 8 bits, inverted), Busy=1; Done moves to after E9.
REQ-025 Macro SEQ_GEN_PARITY_EN undefined: no PARITY state and no parity logic; frame is exactly 8 bits; DONE follows SHIFT directly.

Verification
REQ-026 Clr, then Din=8'hA5, Load for 1 cycle -> X=1,0,1,0,0,1,0,1 on cycles 1-8 after capture; Done=1 on cycle 9 (no parity) or cycle 10 after parity bit X=1 (with SEQ_GEN_PARITY_EN); Ready=1 the following cycle.
REQ-027 Din=8'hFF captured, Load pulsed again at bit 3 with Din=8'h00 -> second Load ignored; X stays 1 for all 8 bits; exactly one Done.
REQ-028 Din=8'hC3 captured, Clr asserted on bit 4 -> next cycle X=0, Ready=1, Busy=0; Done never pulses.
REQ-029 Clr and Load both high with Din=8'h81 -> after the edge Ready=1, X=0, Busy=0; no frame transmitted.
REQ-030 Load held high with Din=8'h5A across two frames -> two identical frames, Load-to-Load spacing exactly 10 cycles (11 with parity), exactly two Done pulses; feed X into a sequence detector for "101" and check the detect count matches a reference model.
